// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Optional ALU_ARBITER_FLAGS_EN adds registered rsp_zero/rsp_neg response flags.
module alu_arbiter #(
  parameter int unsigned PRIO_REQ = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [1:0]  req0_sel,
  output logic        req0_ready,

  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req1_sel,
  output logic        req1_ready,

  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_sel,
  input  logic [15:0] alu_result,

  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
`ifdef ALU_ARBITER_FLAGS_EN
  ,
  output logic        rsp_zero,
  output logic        rsp_neg
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Pointer resets to the non-priority requester so PRIO_REQ wins the first contention.
  localparam logic LastGrantRst = (PRIO_REQ == 0) ? 1'b1 : 1'b0;

  state_e      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [1:0]  op_sel_q, op_sel_d;
  logic        last_grant_q, last_grant_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d;

  logic        any_valid;
  logic        grant_id;

  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Reset wins over a grant, so no requester may see ready during rst.
        if (any_valid && !rst) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          op_a_d       = grant_id ? req1_a   : req0_a;
          op_b_d       = grant_id ? req1_b   : req0_b;
          op_sel_d     = grant_id ? req1_sel : req0_sel;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_a_q       <= 16'h0000;
      op_b_q       <= 16'h0000;
      op_sel_q     <= 2'd0;
      last_grant_q <= LastGrantRst;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARBITER_FLAGS_EN
  logic rsp_zero_q, rsp_zero_d;
  logic rsp_neg_q, rsp_neg_d;

  always_comb begin
    rsp_zero_d = rsp_zero_q;
    rsp_neg_d  = rsp_neg_q;
    if (state_q == StExec) begin
      rsp_zero_d = (alu_result == 16'h0000);
      rsp_neg_d  = alu_result[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else begin
      rsp_zero_q <= rsp_zero_d;
      rsp_neg_q  <= rsp_neg_d;
    end
  end

  assign rsp_zero = rsp_zero_q;
  assign rsp_neg  = rsp_neg_q;
`else
  // Without flags the response is fully described by rsp_id and rsp_data.
`endif

  ready_onehot_a : assert property (@(posedge clk) !(req0_ready && req1_ready));

  ready_idle_only_a : assert property (@(posedge clk)
    (req0_ready || req1_ready) |-> (state_q == StIdle));

  rsp_hold_a : assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of grants and responses.
module tb_alu_arbiter;

  localparam int unsigned Prio = 0;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_sel, req1_sel;
  logic        req0_ready, req1_ready;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_sel;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [15:0] rsp_data;
`ifdef ALU_ARBITER_FLAGS_EN
  logic        rsp_zero, rsp_neg;
`endif

  alu_arbiter #(
    .PRIO_REQ (Prio)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .req1_ready (req1_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg)
`endif
  );

  // Shared combinational ALU seen by the arbiter.
  always_comb begin
    alu_result = 16'h0000;
    case (alu_sel)
      2'd0:    alu_result = alu_a + alu_b;
      2'd1:    alu_result = alu_a - alu_b;
      2'd2:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (transaction level).
  int          cyc = 0;
  int          grant_cyc = 0;
  bit          busy = 1'b0;
  bit          last_win = 1'b1;
  bit          rst_s, g_now, g_id, hs_now;
  logic [15:0] na, nb, n_data;
  logic [1:0]  nsel;
  logic [15:0] exp_a, exp_b, exp_data;
  logic [1:0]  exp_sel;
  bit          exp_id;
  bit          grant_log[$];
  logic [15:0] rsp_log[$];

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] s);
    int unsigned ai, bi, r;
    ai = a;
    bi = b;
    case (s)
      2'd0:    r = (ai + bi) % 65536;
      2'd1:    r = (ai + 65536 - bi) % 65536;
      2'd2:    r = ai & bi;
      default: r = ai | bi;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {15'b0, obs}, {15'b0, exp});
  endtask

  task automatic set_req(input int k, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] s);
    if (k == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
    end
  endtask

  task automatic monitor();
    logic [1:0] exp_rdy;
    bit         win;
    rst_s  = rst;
    g_now  = 1'b0;
    hs_now = 1'b0;
    exp_rdy = 2'b00;
    chk1("ready_onehot", req0_ready & req1_ready, 1'b0);
    if (!busy && !rst && (req0_valid || req1_valid)) begin
      if (req0_valid && req1_valid) win = ~last_win;
      else                          win = req1_valid;
      exp_rdy = win ? 2'b10 : 2'b01;
      g_now = 1'b1;
      g_id  = win;
      na    = win ? req1_a   : req0_a;
      nb    = win ? req1_b   : req0_b;
      nsel  = win ? req1_sel : req0_sel;
      n_data = ref_alu(na, nb, nsel);
      grant_log.push_back(win);
    end
    chk("ready", {14'b0, req1_ready, req0_ready}, {14'b0, exp_rdy});
    if (busy) begin
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
      chk("alu_sel", {14'b0, alu_sel}, {14'b0, exp_sel});
      if (cyc == grant_cyc + 1) begin
        chk1("rsp_valid_exec", rsp_valid, 1'b0);
      end else begin
        chk1("rsp_valid_resp", rsp_valid, 1'b1);
        chk1("rsp_id", rsp_id, exp_id);
        chk("rsp_data", rsp_data, exp_data);
`ifdef ALU_ARBITER_FLAGS_EN
        chk1("rsp_zero", rsp_zero, exp_data == 16'h0000);
        chk1("rsp_neg", rsp_neg, exp_data[15]);
`endif
        if (rsp_ready) begin
          hs_now = 1'b1;
          rsp_log.push_back(rsp_data);
        end
      end
    end else begin
      chk1("rsp_valid_idle", rsp_valid, 1'b0);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    if (rst_s) begin
      busy     = 1'b0;
      last_win = (Prio == 0);
    end else if (g_now) begin
      busy      = 1'b1;
      last_win  = g_id;
      grant_cyc = cyc;
      exp_a     = na;
      exp_b     = nb;
      exp_sel   = nsel;
      exp_id    = g_id;
      exp_data  = n_data;
    end else if (hs_now) begin
      busy = 1'b0;
    end
    cyc++;
  endtask

  task automatic cycle();
    at_neg();
    to_pos();
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 16'h0, 16'h0, 2'd0);
    set_req(1, 1'b1, 16'h1234, 16'h4321, 2'd2);

    // Reset with a request pending: no ready, then reset values.
    cycle();
    cycle();
    rst = 1'b0;
    set_req(1, 1'b0, 16'h0, 16'h0, 2'd0);
    at_neg();
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_sel", {14'b0, alu_sel}, 16'h0000);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
`ifdef ALU_ARBITER_FLAGS_EN
    chk1("rst_rsp_zero", rsp_zero, 1'b0);
    chk1("rst_rsp_neg", rsp_neg, 1'b0);
`endif
    to_pos();

    // Single add from requester 0.
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h0003, 16'h0005, 2'd0);
    at_neg();
    chk1("t27_ready0", req0_ready, 1'b1);
    to_pos();
    req0_valid = 1'b0;
    cycle();
    at_neg();
    chk1("t27_rsp_valid", rsp_valid, 1'b1);
    chk("t27_rsp_data", rsp_data, 16'h0008);
    chk1("t27_rsp_id", rsp_id, 1'b0);
    to_pos();
    cycle();

    // Subtract wrap from requester 1.
    set_req(1, 1'b1, 16'h0000, 16'h0001, 2'd1);
    cycle();
    req1_valid = 1'b0;
    cycle();
    at_neg();
    chk("t28_rsp_data", rsp_data, 16'hFFFF);
    chk1("t28_rsp_id", rsp_id, 1'b1);
`ifdef ALU_ARBITER_FLAGS_EN
    chk1("t28_rsp_neg", rsp_neg, 1'b1);
    chk1("t28_rsp_zero", rsp_zero, 1'b0);
`endif
    to_pos();
    cycle();

    // Continuous contention after reset alternates 0,1,0,1.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    grant_log.delete();
    rsp_log.delete();
    set_req(0, 1'b1, 16'hF0F0, 16'h0FF0, 2'd2);
    set_req(1, 1'b1, 16'hF000, 16'h000F, 2'd3);
    repeat (14) cycle();
    chk1("t29_grant_cnt", grant_log.size() >= 4, 1'b1);
    if (grant_log.size() >= 4) begin
      chk1("t29_grant0", grant_log[0], 1'b0);
      chk1("t29_grant1", grant_log[1], 1'b1);
      chk1("t29_grant2", grant_log[2], 1'b0);
      chk1("t29_grant3", grant_log[3], 1'b1);
    end
    chk1("t29_rsp_cnt", rsp_log.size() >= 2, 1'b1);
    if (rsp_log.size() >= 2) begin
      chk("t29_and", rsp_log[0], 16'h00F0);
      chk("t29_or", rsp_log[1], 16'hF00F);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) cycle();

    // Backpressure: response held, competing request waits.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 16'h0F00, 16'h00F0, 2'd0);
    cycle();
    req0_valid = 1'b0;
    set_req(1, 1'b1, 16'h0007, 16'h0002, 2'd1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk1("t30_rsp_valid", rsp_valid, 1'b1);
      chk("t30_rsp_data", rsp_data, 16'h0FF0);
      chk1("t30_no_ready", req0_ready | req1_ready, 1'b0);
      to_pos();
    end
    rsp_ready = 1'b1;
    cycle();
    at_neg();
    chk1("t30_regrant", req1_ready, 1'b1);
    to_pos();
    req1_valid = 1'b0;
    repeat (3) cycle();

    // Reset during EXEC aborts the op; held request is granted again.
    set_req(0, 1'b1, 16'h0009, 16'h0004, 2'd1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    at_neg();
    chk1("t31_rsp_valid", rsp_valid, 1'b0);
    chk("t31_alu_a", alu_a, 16'h0000);
    chk("t31_alu_b", alu_b, 16'h0000);
    chk("t31_rsp_data", rsp_data, 16'h0000);
    chk1("t31_regrant", req0_ready, 1'b1);
    to_pos();
    req0_valid = 1'b0;
    cycle();
    at_neg();
    chk1("t31_rsp_valid2", rsp_valid, 1'b1);
    chk("t31_rsp_data2", rsp_data, 16'h0005);
    to_pos();
    cycle();

    // Randomized traffic with backpressure and occasional reset.
    for (int n = 0; n < 600; n++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        logic cur_v;
        cur_v = (k == 0) ? req0_valid : req1_valid;
        if (!cur_v || (g_now && !rst_s && (g_id == k[0]))) begin
          if ($urandom_range(0, 99) < 60) begin
            set_req(k, 1'b1,
                    ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                    2'($urandom_range(0, 3)));
          end else begin
            set_req(k, 1'b0, 16'h0, 16'h0, 2'd0);
          end
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      rst       = ($urandom_range(0, 99) < 2);
    end

    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (6) cycle();
    chk1("drain_idle", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: PRIO_REQ, default 0, index (0/1) of the requester that wins the first contended grant after reset.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid  in  1; req0_a  in  16; req0_b  in  16; req0_sel  in  2.
REQ-005 SHALL have port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have ports: req1_valid, req1_a, req1_b, req1_sel, req1_ready, identical to requester 0.
REQ-007 SHALL have ports: alu_a  out  16; alu_b  out  16; alu_sel  out  2; these drive the shared combinational ALU (0 add, 1 sub, 2 and, 3 or).
REQ-008 SHALL have port: alu_result  in  16  ALU output, sampled by the arbiter.
REQ-009 SHALL have ports: rsp_valid  out  1; rsp_id  out  1 (granted requester); rsp_data  out  16; rsp_ready  in  1.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-011 In IDLE with any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally for that cycle only, latch a/b/sel/id, and move to EXEC.
REQ-012 In IDLE with no valid, SHALL stay in IDLE with both ready signals low.
REQ-013 reqN_ready SHALL be low in EXEC and RESP; at most one ready high per cycle.
REQ-014 Single valid SHALL be granted regardless of priority pointer.
REQ-015 Both valid: SHALL grant the requester not granted last (round-robin; last_grant pointer updated on each grant).
REQ-016 alu_a/alu_b/alu_sel SHALL be driven directly from the latched operand registers at all times.
REQ-017 EXEC SHALL last exactly one cycle: capture alu_result into rsp_data, move to RESP.
REQ-018 In RESP SHALL hold rsp_valid=1 with rsp_data/rsp_id stable until rsp_ready=1; transfer completes on that edge, then IDLE.
REQ-019 Latency: accept at cycle N -> rsp_valid high at N+2; minimum 3 cycles per operation.
REQ-020 rsp_data SHALL be the 16-bit ALU result; no width extension, add/sub wrap modulo 2^16.
REQ-021 A request arriving during EXEC/RESP SHALL wait (valid held by requester); operands SHALL not be sampled until granted.

Reset
REQ-022 On rst: state IDLE; rsp_valid 0; rsp_id 0; rsp_data 0; operand registers 0 (alu_a=0, alu_b=0, alu_sel=0); last_grant = ~PRIO_REQ; both ready low.
REQ-023 rst in EXEC or RESP SHALL abort the operation; no response issued for it.
REQ-024 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-025 Macro ALU_ARBITER_FLAGS_EN defined: SHALL add outputs rsp_zero (1, rsp_data==0) and rsp_neg (1, rsp_data[15]), registered at EXEC with rsp_data, reset 0.
REQ-026 Macro undefined: rsp_zero and rsp_neg SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset, req0 a=0x0003 b=0x0005 sel=0 -> req0_ready same cycle, rsp_valid 2 cycles later, rsp_data=0x0008, rsp_id=0.
REQ-028 req1 a=0x0000 b=0x0001 sel=1 -> rsp_data=0xFFFF (wrap), rsp_id=1; with FLAGS_EN rsp_neg=1, rsp_zero=0.
REQ-029 Both valid continuously, PRIO_REQ=0, rsp_ready=1 -> grants alternate 0,1,0,1; ops and 0xF0F0&0x0FF0=0x00F0, or 0xF000|0x000F=0xF00F.
REQ-030 rsp_ready held low 5 cycles in RESP -> rsp_valid/data stable, no ready asserted, no new grant until handshake.
REQ-031 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, outputs at reset values, pending requester re-granted afterward.
